// File: rtl/flash_responder_pkg.sv
// Shared types and constants for the flash_responder CFI NOR flash device model.
package flash_responder_pkg;

  typedef enum logic [2:0] {
    READ_ARRAY,
    READ_STATUS,
    READ_ID,
    PROG_SETUP,
    ERASE_SETUP,
    LOCK_SETUP,
    PROG_BUSY,
    ERASE_BUSY
  } state_t;

  localparam logic [7:0] CMD_READ     = 8'hFF;
  localparam logic [7:0] CMD_STATUS   = 8'h70;
  localparam logic [7:0] CMD_ID       = 8'h90;
  localparam logic [7:0] CMD_CLR      = 8'h50;
  localparam logic [7:0] CMD_PROG     = 8'h40;
  localparam logic [7:0] CMD_PROG_ALT = 8'h10;
  localparam logic [7:0] CMD_ERASE    = 8'h20;
  localparam logic [7:0] CMD_CONFIRM  = 8'hD0;
  localparam logic [7:0] CMD_LOCK     = 8'h60;
  localparam logic [7:0] CMD_LOCKSET  = 8'h01;

  localparam logic [15:0] MANUF_ID = 16'h0089;

  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_LOCK_ERR  = 1;

  function automatic logic is_busy(input state_t s);
    return (s == PROG_BUSY) || (s == ERASE_BUSY);
  endfunction

endpackage

// File: rtl/flash_responder_if.sv
// Flash bus between the FSM-bus initiator (master) and the flash device (slave).
// Strobes are active-low and asynchronous to the device clock: a write is the rising edge
// of we_n while ce_n is low (flash_addr/dq_i stable across it); a read drives dq_o while dq_oe=1.
interface flash_responder_if;
  logic [23:0] flash_addr;
  logic [15:0] dq_i;
  logic [15:0] dq_o;
  logic        dq_oe;
  logic        ce_n;
  logic        oe_n;
  logic        we_n;
  logic        rdybsy_n;

  modport master (
    output flash_addr, dq_i, ce_n, oe_n, we_n,
    input  dq_o, dq_oe, rdybsy_n
  );

  modport slave (
    input  flash_addr, dq_i, ce_n, oe_n, we_n,
    output dq_o, dq_oe, rdybsy_n
  );
endinterface

// File: rtl/flash_strobe_sync.sv
// Two-flop synchronizer for the ce_n/oe_n/we_n strobes plus a we_n rising-edge pulse.
module flash_strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ce_n,
  input  logic oe_n,
  input  logic we_n,
  output logic ce_s,
  output logic oe_s,
  output logic we_s,
  output logic we_rise
);
  logic [2:0] meta;
  logic [2:0] sync;
  logic       we_prev;

  // Strobes idle high, so reset to the deasserted level to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= 3'b111;
      sync    <= 3'b111;
      we_prev <= 1'b1;
    end else begin
      meta    <= {ce_n, oe_n, we_n};
      sync    <= meta;
      we_prev <= sync[0];
    end
  end

  assign {ce_s, oe_s, we_s} = sync;
  assign we_rise = sync[0] & ~we_prev;
endmodule

// File: rtl/flash_responder.sv
// Device-side CFI NOR flash model: array/status/ID reads, word program, block erase.
// Optional per-block locking is compiled in with FLASH_RESPONDER_LOCK_EN.
module flash_responder
  import flash_responder_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          BLK_W       = 6,
  parameter int          PROG_CYCLES = 16,
  parameter logic [15:0] DEVICE_ID   = 16'h891C
) (
  input  logic               sys0_clk,
  input  logic               sys0_rstn,
  flash_responder_if.slave   bus,
  output state_t             dbg_state
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBLK_W = ADDR_W - BLK_W;
  localparam int CNT_W  = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;

  logic ce_s, oe_s, we_s, we_rise;

  flash_strobe_sync u_sync (
    .clk     (sys0_clk),
    .rst_n   (sys0_rstn),
    .ce_n    (bus.ce_n),
    .oe_n    (bus.oe_n),
    .we_n    (bus.we_n),
    .ce_s    (ce_s),
    .oe_s    (oe_s),
    .we_s    (we_s),
    .we_rise (we_rise)
  );

  state_t              state;
  logic [CNT_W-1:0]    busy_cnt;
  logic [NBLK_W-1:0]   erase_blk;
  logic [BLK_W-1:0]    erase_off;
  logic                err_erase, err_prog, err_lock;
  logic                rdybsy_q;
  logic [15:0]         dq_o_q;
  logic                dq_oe_q;
  logic [15:0]         mem [DEPTH];

  logic                wr;
  logic [ADDR_W-1:0]   a;
  logic [NBLK_W-1:0]   blk_a;
  logic [7:0]          cmd;
  logic                busy;
  logic [7:0]          sr;
  logic                blk_locked;
  logic                addr_unused;

  assign wr          = we_rise & ~ce_s;
  assign a           = bus.flash_addr[ADDR_W-1:0];
  assign blk_a       = a[ADDR_W-1:BLK_W];
  assign cmd         = bus.dq_i[7:0];
  assign busy        = is_busy(state);
  assign addr_unused = ^bus.flash_addr[23:ADDR_W];

  always_comb begin
    sr               = 8'h00;
    sr[SR_READY]     = ~busy;
    sr[SR_ERASE_ERR] = err_erase;
    sr[SR_PROG_ERR]  = err_prog;
    sr[SR_LOCK_ERR]  = err_lock;
  end

`ifdef FLASH_RESPONDER_LOCK_EN
  logic [(1<<NBLK_W)-1:0] lock_q;
  assign blk_locked = lock_q[blk_a];
`else
  assign blk_locked = 1'b0;
`endif

  // Program clears bits only; erase streams 0xFFFF through the latched block.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [15:0]       mem_wd;

  always_comb begin
    mem_we = 1'b0;
    mem_wa = a;
    mem_wd = mem[a] & bus.dq_i;
    if (state == PROG_SETUP && wr && !blk_locked) begin
      mem_we = 1'b1;
    end else if (state == ERASE_BUSY) begin
      mem_we = 1'b1;
      mem_wa = {erase_blk, erase_off};
      mem_wd = 16'hFFFF;
    end
  end

  always_ff @(posedge sys0_clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
    if (!sys0_rstn) begin
      state     <= READ_ARRAY;
      busy_cnt  <= '0;
      erase_blk <= '0;
      erase_off <= '0;
      err_erase <= 1'b0;
      err_prog  <= 1'b0;
      err_lock  <= 1'b0;
      rdybsy_q  <= 1'b1;
`ifdef FLASH_RESPONDER_LOCK_EN
      lock_q    <= '1;
`endif
    end else begin
      case (state)
        READ_ARRAY, READ_STATUS, READ_ID: begin
          if (wr) begin
            case (cmd)
              CMD_READ:               state <= READ_ARRAY;
              CMD_STATUS:             state <= READ_STATUS;
              CMD_ID:                 state <= READ_ID;
              CMD_CLR: begin
                err_erase <= 1'b0;
                err_prog  <= 1'b0;
                err_lock  <= 1'b0;
              end
              CMD_PROG, CMD_PROG_ALT: state <= PROG_SETUP;
              CMD_ERASE:              state <= ERASE_SETUP;
              CMD_LOCK:               state <= LOCK_SETUP;
              default:                state <= READ_ARRAY;
            endcase
          end
        end
        PROG_SETUP: begin
          if (wr) begin
            if (blk_locked) begin
              err_lock <= 1'b1;
              err_prog <= 1'b1;
              state    <= READ_STATUS;
            end else begin
              busy_cnt <= CNT_W'(PROG_CYCLES - 1);
              rdybsy_q <= 1'b0;
              state    <= PROG_BUSY;
            end
          end
        end
        ERASE_SETUP: begin
          if (wr) begin
            if (cmd != CMD_CONFIRM) begin
              err_erase <= 1'b1;
              err_prog  <= 1'b1;
              state     <= READ_STATUS;
            end else if (blk_locked) begin
              err_lock  <= 1'b1;
              err_erase <= 1'b1;
              state     <= READ_STATUS;
            end else begin
              erase_blk <= blk_a;
              erase_off <= '0;
              rdybsy_q  <= 1'b0;
              state     <= ERASE_BUSY;
            end
          end
        end
        LOCK_SETUP: begin
          if (wr) begin
`ifdef FLASH_RESPONDER_LOCK_EN
            if (cmd == CMD_LOCKSET) begin
              lock_q[blk_a] <= 1'b1;
            end else if (cmd == CMD_CONFIRM) begin
              lock_q[blk_a] <= 1'b0;
            end else begin
              err_erase <= 1'b1;
              err_prog  <= 1'b1;
            end
            state <= READ_STATUS;
`else
            state <= READ_ARRAY;
`endif
          end
        end
        PROG_BUSY: begin
          if (busy_cnt == '0) begin
            rdybsy_q <= 1'b1;
            state    <= READ_STATUS;
          end else begin
            busy_cnt <= busy_cnt - 1'b1;
          end
        end
        ERASE_BUSY: begin
          erase_off <= erase_off + 1'b1;
          if (&erase_off) begin
            rdybsy_q <= 1'b1;
            state    <= READ_STATUS;
          end
        end
        default: state <= READ_ARRAY;
      endcase
    end
  end

  // While busy every read sees status; setup states also answer with status.
  logic [15:0] rd_data;
  always_comb begin
    rd_data = {8'h00, sr};
    if (!busy) begin
      case (state)
        READ_ARRAY: rd_data = mem[a];
        READ_ID: begin
          case (a[1:0])
            2'd0:    rd_data = MANUF_ID;
            2'd1:    rd_data = DEVICE_ID;
`ifdef FLASH_RESPONDER_LOCK_EN
            2'd2:    rd_data = {15'h0000, lock_q[blk_a]};
`endif
            default: rd_data = 16'h0000;
          endcase
        end
        default: rd_data = {8'h00, sr};
      endcase
    end
  end

  always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
    if (!sys0_rstn) begin
      dq_o_q  <= 16'h0000;
      dq_oe_q <= 1'b0;
    end else begin
      dq_o_q  <= rd_data;
      dq_oe_q <= ~ce_s & ~oe_s & we_s;
    end
  end

  assign bus.dq_o     = dq_o_q;
  assign bus.dq_oe    = dq_oe_q;
  assign bus.rdybsy_n = rdybsy_q;
  assign dbg_state    = state;
endmodule

// File: tb/tb_flash_responder.sv
// Directed self-checking bench for flash_responder (reads, program, erase, ID, status, lock).
module tb_flash_responder;
  import flash_responder_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     vectors;
  int     miscompares;

  flash_responder_if bus ();

  flash_responder dut (
    .sys0_clk  (clk),
    .sys0_rstn (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns the number of sampled clocks with rdybsy_n low following the write.
  task automatic bus_write(input logic [23:0] addr, input logic [15:0] data, output int low);
    @(negedge clk);
    bus.flash_addr = addr;
    bus.dq_i       = data;
    bus.ce_n       = 1'b0;
    repeat (2) @(negedge clk);
    bus.we_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.we_n = 1'b1;
    low = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (!bus.rdybsy_n) low++;
      else if (low > 0 || i >= 8) break;
    end
    @(negedge clk);
    bus.ce_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic bus_read(input logic [23:0] addr, output logic [15:0] data,
                          output logic oe_early, output logic oe_on);
    @(negedge clk);
    bus.flash_addr = addr;
    bus.ce_n       = 1'b0;
    bus.oe_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    oe_early = bus.dq_oe;
    @(posedge clk);
    #1;
    oe_on = bus.dq_oe;
    data  = bus.dq_o;
    @(negedge clk);
    bus.oe_n = 1'b1;
    bus.ce_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic rd_check(input string tag, input logic [23:0] addr, input logic [15:0] exp);
    logic [15:0] d;
    logic e0, e1;
    bus_read(addr, d, e0, e1);
    check(tag, d, exp);
  endtask

  initial begin
    int          lo;
    logic [15:0] d;
    logic        e0, e1;
    vectors     = 0;
    miscompares = 0;
    bus.flash_addr = '0;
    bus.dq_i       = '0;
    bus.ce_n       = 1'b1;
    bus.oe_n       = 1'b1;
    bus.we_n       = 1'b1;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dq_o", bus.dq_o, 16'h0000);
    check("reset_dq_oe", {15'h0, bus.dq_oe}, 16'h0000);
    check("reset_rdybsy", {15'h0, bus.rdybsy_n}, 16'h0001);
    check("reset_state", 16'(dbg_state), 16'(READ_ARRAY));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(24'h0, 16'h0070, lo);
    rd_check("reset_sr", 24'h0, 16'h0080);

`ifdef FLASH_RESPONDER_LOCK_EN
    bus_write(24'h005, 16'h0040, lo);
    bus_write(24'h005, 16'h1234, lo);
    check("locked_prog_busy", 16'(lo), 16'd0);
    rd_check("locked_prog_sr", 24'h0, 16'h0092);
    bus_write(24'h0, 16'h0050, lo);
    rd_check("locked_clr_sr", 24'h0, 16'h0080);
    bus_write(24'h000, 16'h0060, lo);
    bus_write(24'h000, 16'h00D0, lo);
    bus_write(24'h040, 16'h0060, lo);
    bus_write(24'h040, 16'h00D0, lo);
`endif

    // Preload: erase block 0 then program two words.
    bus_write(24'h000, 16'h0020, lo);
    bus_write(24'h000, 16'h00D0, lo);
    check("erase0_busy", 16'(lo), 16'd64);
    bus_write(24'h005, 16'h0040, lo);
    bus_write(24'h005, 16'h1234, lo);
    check("prog_1234_busy", 16'(lo), 16'd16);
    bus_write(24'h03F, 16'h0010, lo);
    bus_write(24'h03F, 16'h5A5A, lo);
    check("prog_5a5a_busy", 16'(lo), 16'd16);
    bus_write(24'h0, 16'h00FF, lo);
    check("state_array", 16'(dbg_state), 16'(READ_ARRAY));

    bus_read(24'h005, d, e0, e1);
    check("oe_early", {15'h0, e0}, 16'h0000);
    check("oe_on", {15'h0, e1}, 16'h0001);
    check("read_1234", d, 16'h1234);
    check("oe_off", {15'h0, bus.dq_oe}, 16'h0000);

    bus_write(24'h005, 16'h0040, lo);
    bus_write(24'h005, 16'h0FF0, lo);
    check("prog_0ff0_busy", 16'(lo), 16'd16);
    rd_check("prog_sr", 24'h0, 16'h0080);
    bus_write(24'h0, 16'h00FF, lo);
    rd_check("prog_and", 24'h005, 16'h0230);

    bus_write(24'h045, 16'h0020, lo);
    bus_write(24'h045, 16'h00D0, lo);
    check("erase1_busy", 16'(lo), 16'd64);
    bus_write(24'h0, 16'h00FF, lo);
    rd_check("erase_040", 24'h040, 16'hFFFF);
    rd_check("erase_05a", 24'h05A, 16'hFFFF);
    rd_check("erase_07f", 24'h07F, 16'hFFFF);
    rd_check("erase_keep_03f", 24'h03F, 16'h5A5A);
    rd_check("erase_keep_005", 24'h005, 16'h0230);

    bus_write(24'h005, 16'h0020, lo);
    bus_write(24'h005, 16'h00AA, lo);
    check("seq_err_busy", 16'(lo), 16'd0);
    rd_check("seq_err_sr", 24'h0, 16'h00B0);
    bus_write(24'h0, 16'h0050, lo);
    rd_check("clr_sr", 24'h0, 16'h0080);
    bus_write(24'h0, 16'h00FF, lo);
    rd_check("seq_err_array", 24'h005, 16'h0230);

    bus_write(24'h0, 16'h0090, lo);
    rd_check("id_manuf", 24'h000, 16'h0089);
    rd_check("id_device", 24'h001, 16'h891C);
    rd_check("id_off3", 24'h003, 16'h0000);
    rd_check("id_lock_blk0", 24'h002, 16'h0000);
`ifdef FLASH_RESPONDER_LOCK_EN
    rd_check("id_lock_blk3", 24'h0C2, 16'h0001);
`endif
    bus_write(24'h0, 16'h00FF, lo);
    rd_check("resume_array", 24'h03F, 16'h5A5A);

`ifndef FLASH_RESPONDER_LOCK_EN
    bus_write(24'h005, 16'h0060, lo);
    bus_write(24'h005, 16'h0040, lo);
    check("lock_consumed_state", 16'(dbg_state), 16'(READ_ARRAY));
    rd_check("lock_consumed_array", 24'h005, 16'h0230);
`endif

    bus_write(24'h0, 16'h0033, lo);
    check("unknown_cmd_state", 16'(dbg_state), 16'(READ_ARRAY));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/flash_responder.md
# flash_responder

Synthesizable device-side model of the 16-bit CFI NOR flash on the shared FSM bus. It answers the flash initiator's `ce_n`/`oe_n`/`we_n` strobes with array reads, status reads, ID reads, word program and block erase, and drives `rdybsy_n`. It is used in board-level simulation and in loopback builds where the on-board flash is absent. Tristating of `fsm_d[15:0]` is done at the top level from `dq_o`/`dq_oe`.

## Interface
- `ADDR_W`, 10: implemented word-address bits; depth is 2^ADDR_W words.
- `BLK_W`, 6: block size is 2^BLK_W words.
- `PROG_CYCLES`, 16: busy duration of a word program, in clocks.
- `DEVICE_ID`, 16'h891C: value returned at ID offset 1.

- `sys0_clk`  in  1  sole clock.
- `sys0_rstn`  in  1  reset, asynchronous, active-low.
- `flash_addr`  in  24  word address; only `[ADDR_W-1:0]` is decoded.
- `dq_i`  in  16  write data from the bus.
- `dq_o`  out  16  read data.
- `dq_oe`  out  1  read-data drive enable.
- `ce_n`, `oe_n`, `we_n`  in  1 each  bus strobes, asynchronous to `sys0_clk`.
- `rdybsy_n`  out  1  0 = busy.

## Operation
- `ce_n`, `oe_n` and `we_n` each pass through a 2-flop synchronizer; these are the `*_s` signals.
- A write is the rising edge of `we_s` while `ce_s`=0. On that edge `flash_addr` and `dq_i` are captured; they are not synchronized and must be stable across the edge.
- Command byte is `dq_i[7:0]`.
- State machine:
  - READ_ARRAY, the reset state.
  - READ_STATUS.
  - READ_ID.
  - PROG_SETUP.
  - ERASE_SETUP.
  - LOCK_SETUP.
  - PROG_BUSY.
  - ERASE_BUSY.
- Commands accepted in READ_* states:
  - 0xFF → READ_ARRAY.
  - 0x70 → READ_STATUS.
  - 0x90 → READ_ID.
  - 0x50 clears SR[5:1] and leaves the state unchanged.
  - 0x40 or 0x10 → PROG_SETUP.
  - 0x20 → ERASE_SETUP.
  - 0x60 → LOCK_SETUP (see Configuration).
  - Any other byte → READ_ARRAY.
- PROG_SETUP, next write:
  - `mem[a] <= mem[a] & data`; NOR programming only clears bits.
  - Start busy counter at PROG_CYCLES-1 and go to PROG_BUSY.
- ERASE_SETUP, next write:
  - 0xD0: go to ERASE_BUSY. The block index `a[ADDR_W-1:BLK_W]` is latched and an offset counter starts at 0. One word per clock is written to 0xFFFF, 2^BLK_W clocks in total.
  - Any other byte: set SR5 and SR4 (sequence error) and go to READ_STATUS.
- Busy counter and offset counter wrap to READ_STATUS when done.
- Status register SR[7:0]:
  - SR7 = ready, which is `~busy`.
  - SR5 = erase error.
  - SR4 = program error.
  - SR1 = lock error.
  - All other bits 0.
- While busy:
  - Every read returns SR regardless of mode.
  - Writes are ignored.
- Read mux, by state:
  - READ_ARRAY: `mem[addr]`.
  - READ_STATUS: {8'h00, SR}.
  - READ_ID, offset `addr[1:0]`:
    - 0: 0x0089.
    - 1: DEVICE_ID.
    - 2: block lock bit when lock support is compiled in; otherwise 0.
    - 3: 0.
- `rdybsy_n` = `~busy`.
- The memory array is not reset. Reset mid-operation aborts a program or erase. Erase words already written stay 0xFFFF.

## Timing
- Reset values:
  - `dq_o` = 0.
  - `dq_oe` = 0.
  - `rdybsy_n` = 1.
  - State READ_ARRAY.
  - SR = 0x80.
- Strobe to action: 2 clocks of synchronizer plus 1 clock of edge detect.
- Read enables:
  - `dq_oe` is registered from `~ce_s & ~oe_s`. It rises 3 clocks after `ce_n`/`oe_n` fall and falls 3 clocks after either rises.
  - `dq_o` is registered every clock, so an address change shows on `dq_o` 1 clock later.
- Command write: the state changes on the clock after the synchronized `we_n` rising edge is detected.
- Program timing:
  - `rdybsy_n` falls on that clock and stays low exactly PROG_CYCLES clocks.
  - The array update is visible on the first busy clock.
- Erase: `rdybsy_n` stays low exactly 2^BLK_W clocks.
- If `we_s` and `oe_s` are both low, the write takes priority and `dq_oe` is forced to 0.

## Configuration
- `FLASH_RESPONDER_LOCK_EN` defined:
  - One lock bit per block; all blocks are locked at reset.
  - In LOCK_SETUP, next write: 0x01 locks the addressed block, 0xD0 unlocks it, any other byte sets SR5|SR4. All three return to READ_STATUS.
  - A program or erase to a locked block sets SR1 plus SR4 (program) or SR5 (erase), leaves the array unchanged, has no busy period, and goes to READ_STATUS.
- Macro undefined:
  - No lock bits exist and all blocks are writable.
  - 0x60 goes to LOCK_SETUP; the next write is consumed and ignored, and the state returns to READ_ARRAY.

## Structure
- Package `flash_responder_pkg`:
  - State enum.
  - Command byte constants: CMD_READ 0xFF, CMD_STATUS 0x70, CMD_ID 0x90, CMD_CLR 0x50, CMD_PROG 0x40/0x10, CMD_ERASE 0x20, CMD_CONFIRM 0xD0, CMD_LOCK 0x60, CMD_LOCKSET 0x01.
  - Manufacturer ID 0x0089.
  - SR bit indices.
- Sub-module `flash_strobe_sync`: 2-flop synchronizer for the three strobes, plus `we_n` rising-edge detect. Instantiated once.

## Test plan
- Reset, then read addr 0x005 after a bench preload of 0x1234: `dq_oe` rises 3 clocks after `oe_n` falls and `dq_o` = 0x1234.
- Write 0x40 then, at addr 0x005, 0x0FF0: `rdybsy_n` is low for 16 clocks, a status read gives 0x0080 once ready, and the array read gives 0x0230.
- Write 0x20 then 0xD0 at addr 0x045: `rdybsy_n` is low for 64 clocks, and words 0x040–0x07F read 0xFFFF while 0x03F is unchanged.
- Write 0x20 then 0xAA: SR = 0xB0 and the array is unchanged. Then write 0x50: SR = 0x80.
- Write 0x90, then read offsets 0/1: 0x0089 and 0x891C. Write 0xFF: array reads resume.
- With `FLASH_RESPONDER_LOCK_EN`, program to a locked block: SR = 0x92, no busy period. Then 0x60 and 0xD0, then program again: it succeeds.
